// File: rtl/gb_stencil_gen_if.sv
// Stream interface bundle for gb_stencil_gen: raster pixel input (arg_1)
// and KxK stencil output (arg_0). The slave modport is the stencil
// generator's view and the master modport is the surrounding pipeline's view.
// The TLAST wire exists only when GB_STENCIL_TLAST_EN is defined.
interface gb_stencil_gen_if #(
    parameter int PIX_W = 8,
    parameter int K     = 9
);
    logic [PIX_W-1:0]     arg_1_TDATA;
    logic                 arg_1_TVALID;
    logic                 arg_1_TREADY;
    logic [PIX_W*K*K-1:0] arg_0_TDATA;
    logic                 arg_0_TVALID;
    logic                 arg_0_TREADY;
`ifdef GB_STENCIL_TLAST_EN
    logic                 arg_0_TLAST;
`endif

    modport slave (
        input  arg_1_TDATA,
        input  arg_1_TVALID,
        output arg_1_TREADY,
        output arg_0_TDATA,
        output arg_0_TVALID,
        input  arg_0_TREADY
`ifdef GB_STENCIL_TLAST_EN
        , output arg_0_TLAST
`endif
    );

    modport master (
        output arg_1_TDATA,
        output arg_1_TVALID,
        input  arg_1_TREADY,
        input  arg_0_TDATA,
        input  arg_0_TVALID,
        output arg_0_TREADY
`ifdef GB_STENCIL_TLAST_EN
        , input arg_0_TLAST
`endif
    );
endinterface

// File: rtl/gb_stencil_gen.sv
// gb_stencil_gen: parametrised line buffer and KxK stencil generator for the
// Gaussian-blur pipeline. Consumes a raster pixel stream and emits one window
// per fully-inside position, one output register deep.
// Optional feature: define GB_STENCIL_TLAST_EN to add arg_0_TLAST, which
// marks the last stencil of each frame.
module gb_stencil_gen #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 512,
    parameter int IMG_H = 480,
    parameter int K     = 9
) (
    input logic              clk,
    input logic              rst,
    gb_stencil_gen_if.slave  bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int SW = PIX_W * K * K;
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] X_FIRST = XW'(K - 1);
    localparam logic [YW-1:0] Y_FIRST = YW'(K - 1);

    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [PIX_W-1:0] lineMem_q [K-1][IMG_W];
    logic [PIX_W-1:0] win_q     [K][K];
    logic [PIX_W-1:0] win_d     [K][K];
    logic [PIX_W-1:0] winShift  [K][K];
    logic [PIX_W-1:0] newCol    [K];
    logic [SW-1:0]    data_q, data_d;
    logic             valid_q, valid_d;
    logic             ready;
    logic             accept;
    logic             load;
    logic             lastPix;

    // Reset wins over everything, so no pixel is taken while it is asserted;
    // ready is forced high in reset so upstream never sees a stale stall.
    assign ready   = rst || !valid_q || bus.arg_0_TREADY;
    assign accept  = bus.arg_1_TVALID && ready && !rst;
    assign load    = accept && (x_q >= X_FIRST) && (y_q >= Y_FIRST);
    assign lastPix = (x_q == X_LAST) && (y_q == Y_LAST);

    assign bus.arg_1_TREADY = ready;
    assign bus.arg_0_TDATA  = data_q;
    assign bus.arg_0_TVALID = valid_q;

    // Build the incoming column (oldest row first, new pixel last) and the window shifted left by one column.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            newCol[r] = lineMem_q[r][x_q];
        end
        newCol[K-1] = bus.arg_1_TDATA;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                winShift[r][c] = win_q[r][c+1];
            end
            winShift[r][K-1] = newCol[r];
        end
    end

    // Next-state for window, raster counters, and the output register.
    always_comb begin
        win_d   = win_q;
        x_d     = x_q;
        y_d     = y_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (accept) begin
            win_d = winShift;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        if (load) begin
            valid_d = 1'b1;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    data_d[(r*K+c)*PIX_W +: PIX_W] = winShift[r][c];
                end
            end
        end else if (bus.arg_0_TREADY) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            win_q   <= win_d;
        end
    end

    // Line-buffer RAM write-back: each row moves up one slot at this column.
    // Not reset; rows are always rewritten before they reach an emitted window.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K - 1; r++) begin
                lineMem_q[r][x_q] <= newCol[r+1];
            end
        end
    end

`ifdef GB_STENCIL_TLAST_EN
    logic last_q, last_d;

    // TLAST follows the stencil it belongs to: loaded with it, held with it, cleared with valid.
    always_comb begin
        last_d = last_q;
        if (load) begin
            last_d = lastPix;
        end else if (bus.arg_0_TREADY) begin
            last_d = 1'b0;
        end
    end

    // TLAST register.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign bus.arg_0_TLAST = last_q;
`else
    logic unusedLast;
    assign unusedLast = lastPix;
`endif
endmodule

// File: tb/tb_gb_stencil_gen.sv
// Self-checking bench for gb_stencil_gen (8-bit pixels, 8x6 image, 3x3 window).
// A reference model keeps the accepted image as a 2-D array and derives every
// expected window directly from pixel coordinates.
module tb_gb_stencil_gen;
    localparam int PIX_W = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int K     = 3;
    localparam int SW    = PIX_W * K * K;
    localparam int NPIX  = IMG_W * IMG_H;

    typedef struct {
        logic [SW-1:0] data;
        logic          last;
    } stencil_t;

    logic clk;
    logic rst;

    gb_stencil_gen_if #(.PIX_W(PIX_W), .K(K)) bus ();

    gb_stencil_gen #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .K(K)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int testCount = 0;
    int failCount = 0;

    stencil_t      expQ [$];
    logic [SW-1:0] gotQ [$];
    logic [PIX_W-1:0] img [IMG_H][IMG_W];
    int   px = 0;
    bit   prevRst = 0;
    bit   expectValidNext = 0;
    bit   holdPending = 0;
    logic [SW-1:0] holdData;
    int   stallCnt = 0;

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference window for the pixel just placed at (x,y): rows y-K+1..y, columns x-K+1..x.
    function automatic logic [SW-1:0] windowAt(input int x, input int y);
        logic [SW-1:0] d;
        d = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                d[(r*K+c)*PIX_W +: PIX_W] = img[y-K+1+r][x-K+1+c];
            end
        end
        return d;
    endfunction

    // Ramp window whose top-left pixel is (x0,y0), plus an offset.
    function automatic logic [SW-1:0] rampWindow(input int x0, input int y0, input int offset);
        logic [SW-1:0] d;
        d = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                d[(r*K+c)*PIX_W +: PIX_W] = PIX_W'((y0 + r) * IMG_W + x0 + c + offset);
            end
        end
        return d;
    endfunction

    // Monitor: samples every handshake at the falling edge and runs the reference model.
    always @(negedge clk) begin
        if (prevRst) begin
            checkOutput("rst_valid", bus.arg_0_TVALID, 1'b0);
            checkOutput("rst_data", bus.arg_0_TDATA, '0);
            checkOutput("rst_ready", bus.arg_1_TREADY, 1'b1);
`ifdef GB_STENCIL_TLAST_EN
            checkOutput("rst_last", bus.arg_0_TLAST, 1'b0);
`endif
        end
        if (rst) begin
            checkOutput("ready_in_rst", bus.arg_1_TREADY, 1'b1);
            expQ.delete();
            px = 0;
            expectValidNext = 0;
            holdPending = 0;
            prevRst = 1;
        end else begin
            prevRst = 0;
            checkOutput("ready_rule", bus.arg_1_TREADY, !bus.arg_0_TVALID || bus.arg_0_TREADY);
            if (expectValidNext) begin
                checkOutput("latency", bus.arg_0_TVALID, 1'b1);
            end
            if (holdPending) begin
                checkOutput("hold_valid", bus.arg_0_TVALID, 1'b1);
                checkOutput("hold_data", bus.arg_0_TDATA, holdData);
            end
            if (bus.arg_0_TVALID && bus.arg_0_TREADY) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_stencil", 1'b1, 1'b0);
                end else begin
                    stencil_t e;
                    e = expQ.pop_front();
                    checkOutput("stencil", bus.arg_0_TDATA, e.data);
`ifdef GB_STENCIL_TLAST_EN
                    checkOutput("tlast", bus.arg_0_TLAST, e.last);
`endif
                end
                gotQ.push_back(bus.arg_0_TDATA);
            end
            expectValidNext = 0;
            if (bus.arg_1_TVALID && bus.arg_1_TREADY) begin
                int x, y;
                x = px % IMG_W;
                y = px / IMG_W;
                img[y][x] = bus.arg_1_TDATA;
                if (x >= K - 1 && y >= K - 1) begin
                    stencil_t s;
                    s.data = windowAt(x, y);
                    s.last = (x == IMG_W - 1) && (y == IMG_H - 1);
                    expQ.push_back(s);
                    expectValidNext = 1;
                end
                px = (px + 1) % NPIX;
            end
            holdPending = bus.arg_0_TVALID && !bus.arg_0_TREADY;
            holdData    = bus.arg_0_TDATA;
        end
    end

    // Streams numPix pixels. readyMode: 0 always ready, 1 random, 2 stall stencil #4 for 5 cycles, 3 never ready.
    task automatic applyStimulus(input int offset, input bit randomPix, input bit bubbles,
                                 input int readyMode, input int numPix);
        int  sent = 0;
        int  cycles = 0;
        bit  tog = 1;
        stallCnt = 0;
        while (sent < numPix && cycles < 2000) begin
            @(posedge clk);
            #1;
            tog = bubbles ? ~tog : 1'b1;
            bus.arg_1_TVALID = tog;
            bus.arg_1_TDATA  = randomPix ? PIX_W'($urandom_range(0, 255)) : PIX_W'(sent + offset);
            case (readyMode)
                1: bus.arg_0_TREADY = 1'($urandom_range(0, 1));
                2: begin
                    if (gotQ.size() == 3 && bus.arg_0_TVALID && stallCnt < 5) begin
                        bus.arg_0_TREADY = 1'b0;
                        stallCnt++;
                    end else begin
                        bus.arg_0_TREADY = 1'b1;
                    end
                end
                3: bus.arg_0_TREADY = 1'b0;
                default: bus.arg_0_TREADY = 1'b1;
            endcase
            @(negedge clk);
            if (bus.arg_1_TVALID && bus.arg_1_TREADY) sent++;
            cycles++;
        end
        if (sent < numPix) checkOutput("stim_timeout", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.arg_1_TVALID = 1'b0;
    endtask

    // Lets every queued stencil leave, with a bounded wait.
    task automatic drainOutput();
        int cycles = 0;
        bus.arg_0_TREADY = 1'b1;
        while ((expQ.size() != 0 || bus.arg_0_TVALID) && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 200) checkOutput("drain_timeout", 1'b1, 1'b0);
    endtask

    initial begin
        logic [SW-1:0] d;
        bus.arg_1_TVALID = 1'b1;
        bus.arg_1_TDATA  = 8'h55;
        bus.arg_0_TREADY = 1'b1;
        rst = 1'b1;

        // Reset held 3 cycles with input valid high.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.arg_1_TVALID = 1'b0;
        @(negedge clk);

        // Ramp frame, always ready.
        gotQ.delete();
        applyStimulus(0, 0, 0, 0, NPIX);
        drainOutput();
        checkOutput("ramp_count", gotQ.size(), 24);
        if (gotQ.size() == 24) begin
            checkOutput("ramp_first", gotQ[0], rampWindow(0, 0, 0));
            checkOutput("ramp_last", gotQ[23], rampWindow(5, 3, 0));
        end

        // Backpressure on stencil #4.
        gotQ.delete();
        applyStimulus(0, 0, 0, 2, NPIX);
        drainOutput();
        checkOutput("bp_stall_len", stallCnt, 5);
        checkOutput("bp_count", gotQ.size(), 24);
        if (gotQ.size() == 24) begin
            checkOutput("bp_4th", gotQ[3], rampWindow(3, 0, 0));
            checkOutput("bp_5th", gotQ[4], rampWindow(4, 0, 0));
        end

        // Input bubbles with random downstream ready.
        gotQ.delete();
        applyStimulus(0, 0, 1, 1, NPIX);
        drainOutput();
        checkOutput("bubble_count", gotQ.size(), 24);

        // Two back-to-back frames, second one offset by 100.
        gotQ.delete();
        applyStimulus(0, 0, 0, 0, NPIX);
        applyStimulus(100, 0, 0, 0, NPIX);
        drainOutput();
        checkOutput("two_count", gotQ.size(), 48);
        if (gotQ.size() == 48) begin
            d = gotQ[24];
            checkOutput("f2_el00", d[7:0], 100);
            checkOutput("f2_el22", d[71:64], 118);
        end

        // Random pixels, bubbles and random ready.
        gotQ.delete();
        applyStimulus(0, 1, 1, 1, NPIX);
        drainOutput();
        checkOutput("rand_count", gotQ.size(), 24);

        // Reset mid-frame with a stalled pending stencil.
        gotQ.delete();
        applyStimulus(0, 0, 0, 3, 19);
        @(negedge clk);
        checkOutput("pending_valid", bus.arg_0_TVALID, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.arg_0_TREADY = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_valid", bus.arg_0_TVALID, 1'b0);
        gotQ.delete();
        applyStimulus(0, 0, 0, 0, NPIX);
        drainOutput();
        checkOutput("after_rst_count", gotQ.size(), 24);
        if (gotQ.size() == 24) begin
            checkOutput("after_rst_first", gotQ[0], rampWindow(0, 0, 0));
            checkOutput("after_rst_last", gotQ[23], rampWindow(5, 3, 0));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
